switch_input_arbiter: RTL and testbench
=======================================

Name: switch_input_arbiter

Overview:
- Shares the single input of the 1-to-4 packet switch (ready_in / data_in / port_num) among N_SRC upstream sources.
- Each source presents one beat at a time: a byte plus a destination port.
- The arbiter grants sources round-robin, holds a grant for a burst of up to MAX_BURST beats, drops beats addressed to disabled ports, and drives the switch input from registers.
- Sits directly in front of the switch; the switch outputs are untouched.

Parameters:
- N_SRC, 4, number of requesting sources (2..8).
- MAX_BURST, 4, maximum consecutive beats per grant (1..16).
- DW, 8, data width; must match the switch data_in.
- PW, 2, port-number width; the switch has 2**PW output ports.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- src_valid  input  N_SRC  per-source beat valid; the source holds it until acked.
- src_data  input  N_SRC*DW  per-source byte; source i occupies bits [i*DW +: DW].
- src_port  input  N_SRC*PW  per-source destination port; source i occupies bits [i*PW +: PW].
- src_ack  output  N_SRC  combinational one-hot pulse; the beat of that source is consumed this cycle.
- port_en  input  2**PW  static enable mask per destination port.
- ready_in  output  1  registered; to the switch.
- data_in  output  DW  registered; to the switch.
- port_num  output  PW  registered; to the switch.
- drop_pulse  output  1  registered; one-cycle pulse when an acked beat was discarded.
- busy  output  1  high while in state BURST.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, beat_cnt=0, owner=0, ready_in=0, data_in=0, port_num=0, drop_pulse=0. src_ack=0 while reset is high.
- A reset asserted mid-burst aborts the burst. No ack is issued in the reset cycle, and the source keeps its beat pending.
- IDLE state:
  - Search src_valid starting at rr_ptr, wrapping modulo N_SRC; the first valid index wins.
  - If there is a winner: owner=i, src_ack[i]=1, beat_cnt=1, go to BURST.
  - If there is no winner: stay in IDLE and ack nothing.
- BURST state:
  - Continue if src_valid[owner]=1 and beat_cnt<MAX_BURST: ack owner, beat_cnt++, stay in BURST.
  - Otherwise release: no ack, rr_ptr=(owner+1) mod N_SRC, beat_cnt=0, go to IDLE.
  - A release always costs exactly one cycle with no accepted beat. Back-to-back bursts from different sources are therefore separated by one idle cycle on ready_in.
- MAX_BURST=1: the grant is released after every beat, giving strict per-beat round-robin with a bubble between beats.
- Switch drive, with one-cycle latency from ack to output:
  - Cycle after an ack with port_en[src_port[owner]]=1: ready_in=1, data_in=accepted byte, port_num=accepted port.
  - Cycle after an ack with the destination disabled: ready_in=0, data_in=0, drop_pulse=1, port_num holds its previous value.
  - Cycle with no ack: ready_in=0, data_in=0, port_num holds its previous value.
  - data_in is 0 whenever ready_in is 0, as the switch checks require.
  - port_num changes only on cycles where ready_in=1 or at reset, so the switch's ready_out decoding never sees a spurious port change.
- The sampled values are src_data, src_port and port_en in the ack cycle. A port_en change takes effect for beats acked from that cycle on.
- Simultaneous requests: only the rr_ptr winner is acked; the others wait. The owner's requests are not blocked by other sources during its burst.
- beat_cnt width is clog2(MAX_BURST+1) and never overflows.

Decomposition:
- Package switch_arb_pkg holds:
  - the state enum {IDLE, BURST};
  - default DW/PW constants;
  - a next_rr(ptr, N) helper function.
- One natural sub-module: rr_pick. It is a combinational rotating priority encoder with inputs req[N_SRC] and ptr, and outputs a one-hot grant plus a found flag. It is reusable by other switch controllers.

Test Plan:
- Single source, MAX_BURST=4:
  - Stimulus: src0 holds valid for 6 beats with data 0x11..0x16 and port 2.
  - Expected: acks on cycles 1-4, no ack on cycle 5 (release), acks on cycles 6-7.
  - Expected: ready_in pattern 1111_0_11; data_in 0x11..0x16; port_num=2; ready_in rises one cycle after the first ack.
- All four sources valid continuously, MAX_BURST=2, each with a distinct port:
  - Expected grant order 0,0,-,1,1,-,2,2,-,3,3,-,0; port_num follows 0,1,2,3.
- Disabled port:
  - Stimulus: port_en=4'b1011; src1 sends 0xA5 to port 2.
  - Expected: src_ack[1] pulses; next cycle ready_in=0, data_in=0, drop_pulse=1, port_num unchanged.
  - Then src1 sends 0x5A to port 3: ready_in=1, port_num=3.
- Early release:
  - Stimulus: src2 drops valid after 1 beat while src3 is valid.
  - Expected: one idle cycle, then src3 is granted with rr_ptr=3; busy deasserts for exactly one cycle.
- Reset mid-burst:
  - Stimulus: reset asserted for 1 cycle on the 2nd beat of src0's burst.
  - Expected: no ack that cycle; all outputs 0 the next cycle; rr_ptr=0; src0 is re-granted first after reset deasserts.
- Wrap-around:
  - Stimulus: rr_ptr=3 with src3 idle and src0 and src1 valid.
  - Expected: src0 is granted, not src1.

Source files
------------

// File: rtl/switch_arb_pkg.sv
// Shared types and helpers for the switch input arbiter and related controllers.
package switch_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int DEF_DW = 8;
   localparam int DEF_PW = 2;

   // Debug view of the arbiter; fields are sized for the largest supported N_SRC/MAX_BURST
   typedef struct packed {
      arb_state_t state;
      logic [2:0] rr_ptr;
      logic [2:0] owner;
      logic [4:0] beat_cnt;
   } arb_dbg_t;

   function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/switch_input_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first set request at or after ptr, wrapping.
module rr_pick #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic             found
);

   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         int unsigned idx;
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_input_arbiter.sv
// Round-robin burst arbiter that multiplexes N_SRC beat sources onto the single
// registered input of the 1-to-4 packet switch, dropping beats for disabled ports.
module switch_input_arbiter
   import switch_arb_pkg::*;
#(
   parameter int N_SRC     = 4,
   parameter int MAX_BURST = 4,
   parameter int DW        = DEF_DW,
   parameter int PW        = DEF_PW
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_SRC-1:0]    src_valid,
   input  logic [N_SRC*DW-1:0] src_data,
   input  logic [N_SRC*PW-1:0] src_port,
   output logic [N_SRC-1:0]    src_ack,
   input  logic [2**PW-1:0]    port_en,
   output logic                ready_in,
   output logic [DW-1:0]       data_in,
   output logic [PW-1:0]       port_num,
   output logic                drop_pulse,
   output logic                busy,
   output arb_dbg_t            dbg
);

   // Handshake: a source raises src_valid[i] with its beat and holds it; the beat is
   // consumed in any cycle where src_ack[i] is high (combinational, at most one per cycle).

   localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int CW    = $clog2(MAX_BURST + 1);

   arb_state_t       state, state_next;
   logic [PTR_W-1:0] rr_ptr, rr_next;
   logic [PTR_W-1:0] owner, owner_next;
   logic [CW-1:0]    beat_cnt, cnt_next;

   logic [N_SRC-1:0] pick_grant;
   logic             pick_found;
   logic [PTR_W-1:0] pick_idx;

   logic             ack_any;
   logic [DW-1:0]    sel_data;
   logic [PW-1:0]    sel_port;
   logic             sel_en;

   rr_pick #(.N(N_SRC), .PTR_W(PTR_W)) u_pick (
      .req   (src_valid),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .found (pick_found)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (pick_grant[i]) pick_idx = PTR_W'(i);
      end
   end

   always_comb begin
      state_next = state;
      rr_next    = rr_ptr;
      owner_next = owner;
      cnt_next   = beat_cnt;
      src_ack    = '0;
      if (!reset) begin
         unique case (state)
            IDLE: begin
               if (pick_found) begin
                  owner_next = pick_idx;
                  src_ack    = pick_grant;
                  cnt_next   = CW'(1);
                  state_next = BURST;
               end
            end
            BURST: begin
               if (src_valid[owner] && (beat_cnt < CW'(MAX_BURST))) begin
                  src_ack[owner] = 1'b1;
                  cnt_next       = beat_cnt + CW'(1);
               end else begin
                  // Release costs one beat-less cycle so the next search sees a fresh pointer
                  rr_next    = PTR_W'(next_rr(int'(owner), N_SRC));
                  cnt_next   = '0;
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // owner_next names the acked source in both states
   assign ack_any  = |src_ack;
   assign sel_data = src_data[int'(owner_next)*DW +: DW];
   assign sel_port = src_port[int'(owner_next)*PW +: PW];
   assign sel_en   = port_en[sel_port];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         owner      <= '0;
         beat_cnt   <= '0;
         ready_in   <= 1'b0;
         data_in    <= '0;
         port_num   <= '0;
         drop_pulse <= 1'b0;
      end else begin
         state      <= state_next;
         rr_ptr     <= rr_next;
         owner      <= owner_next;
         beat_cnt   <= cnt_next;
         ready_in   <= ack_any && sel_en;
         data_in    <= (ack_any && sel_en) ? sel_data : '0;
         drop_pulse <= ack_any && !sel_en;
         // port_num only moves with an accepted beat so the switch never sees a stray change
         if (ack_any && sel_en) port_num <= sel_port;
      end
   end

   assign busy = (state == BURST);

   assign dbg.state    = state;
   assign dbg.rr_ptr   = 3'(rr_ptr);
   assign dbg.owner    = 3'(owner);
   assign dbg.beat_cnt = 5'(beat_cnt);

endmodule

// File: tb/tb_switch_input_arbiter.sv
// Directed bench for switch_input_arbiter: MAX_BURST=4 instance for most scenarios,
// a MAX_BURST=2 instance for the four-way round-robin sequence.
module tb_switch_input_arbiter;
   import switch_arb_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // instance A: MAX_BURST=4
   logic [3:0]  src_valid;
   logic [31:0] src_data;
   logic [7:0]  src_port;
   logic [3:0]  src_ack;
   logic [3:0]  port_en;
   logic        ready_in;
   logic [7:0]  data_in;
   logic [1:0]  port_num;
   logic        drop_pulse;
   logic        busy;
   arb_dbg_t    dbg;

   // instance B: MAX_BURST=2
   logic [3:0]  v2;
   logic [31:0] d2;
   logic [7:0]  p2;
   logic [3:0]  ack2;
   logic [3:0]  en2;
   logic        ready2;
   logic [7:0]  data2;
   logic [1:0]  port2;
   logic        drop2;
   logic        busy2;
   arb_dbg_t    dbg2;

   switch_input_arbiter #(.N_SRC(4), .MAX_BURST(4), .DW(8), .PW(2)) dut (
      .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
      .src_port(src_port), .src_ack(src_ack), .port_en(port_en), .ready_in(ready_in),
      .data_in(data_in), .port_num(port_num), .drop_pulse(drop_pulse), .busy(busy),
      .dbg(dbg)
   );

   switch_input_arbiter #(.N_SRC(4), .MAX_BURST(2), .DW(8), .PW(2)) dut2 (
      .clk(clk), .reset(reset), .src_valid(v2), .src_data(d2),
      .src_port(p2), .src_ack(ack2), .port_en(en2), .ready_in(ready2),
      .data_in(data2), .port_num(port2), .drop_pulse(drop2), .busy(busy2),
      .dbg(dbg2)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic v, input logic [7:0] d, input logic [1:0] p);
      src_valid[i]     = v;
      src_data[i*8 +: 8] = d;
      src_port[i*2 +: 2] = p;
   endtask

   function automatic int onehot_idx(input logic [3:0] oh);
      int r = 0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = i;
      return r;
   endfunction

   task automatic check_out(input string tag, input logic r, input logic [7:0] d,
                            input logic [1:0] p, input logic dr);
      check({tag, "_ready"}, 32'(ready_in), 32'(r));
      check({tag, "_data"},  32'(data_in),  32'(d));
      check({tag, "_port"},  32'(port_num), 32'(p));
      check({tag, "_drop"},  32'(drop_pulse), 32'(dr));
   endtask

   initial begin
      logic [3:0]  t1_ack [9];
      logic        t1_busy[9];
      logic [3:0]  t2_ack [13];
      logic        prev_r;
      logic [3:0]  prev_oh;
      logic [31:0] exp_d;
      logic [1:0]  exp_p;
      int          beat;

      t1_ack  = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0};
      t1_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      t2_ack  = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0,
                  4'h8, 4'h8, 4'h0, 4'h1};

      // ---- reset ----
      reset = 1'b1;
      src_valid = 4'b0001; src_data = '0; src_port = '0; port_en = 4'hF;
      v2 = '0; d2 = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; p2 = 8'hE4; en2 = 4'hF;
      tick();
      tick();
      check("rst_ack", 32'(src_ack), 32'h0);
      check_out("rst", 1'b0, 8'h00, 2'd0, 1'b0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_rr", 32'(dbg.rr_ptr), 32'h0);
      check("rst_cnt", 32'(dbg.beat_cnt), 32'h0);
      src_valid = '0;
      reset = 1'b0;
      tick();

      // ---- single source, bursts of 4 with a release bubble ----
      for (int b = 0; b < 6; b++) exp_q.push_back(32'h11 + b);
      beat = 0;
      prev_r = 1'b0;
      for (int c = 0; c < 9; c++) begin
         set_src(0, beat < 6, 8'(8'h11 + beat), 2'd2);
         #1;
         check("t1_ack", 32'(src_ack), 32'(t1_ack[c]));
         check("t1_busy", 32'(busy), 32'(t1_busy[c]));
         check("t1_ready", 32'(ready_in), 32'(prev_r));
         if (prev_r) begin
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            check("t1_data", 32'(data_in), exp_d);
         end else begin
            check("t1_data0", 32'(data_in), 32'h0);
         end
         check("t1_port", 32'(port_num), (c == 0) ? 32'd0 : 32'd2);
         if (src_ack[0]) beat++;
         prev_r = (t1_ack[c] != 4'h0);
         tick();
      end
      check("t1_q_drained", 32'(exp_q.size()), 32'd0);
      src_valid = '0;

      // ---- round robin, MAX_BURST=2, all four sources busy ----
      v2 = 4'hF;
      prev_oh = 4'h0;
      exp_p = 2'd0;
      for (int c = 0; c < 13; c++) begin
         #1;
         check("t2_ack", 32'(ack2), 32'(t2_ack[c]));
         if (prev_oh != 4'h0) exp_p = 2'(onehot_idx(prev_oh));
         check("t2_ready", 32'(ready2), 32'(prev_oh != 4'h0));
         check("t2_data", 32'(data2), (prev_oh != 4'h0) ? 32'(8'hA0 + exp_p) : 32'h0);
         check("t2_port", 32'(port2), 32'(exp_p));
         prev_oh = t2_ack[c];
         tick();
      end
      v2 = '0;
      tick();
      tick();

      // ---- early release: src2 leaves after one beat, src3 follows ----
      set_src(2, 1'b1, 8'h22, 2'd1);
      set_src(3, 1'b1, 8'h33, 2'd0);
      #1;
      check("er0_ack", 32'(src_ack), 32'h4);
      check("er0_busy", 32'(busy), 32'h0);
      tick();
      set_src(2, 1'b0, 8'h22, 2'd1);
      #1;
      check("er1_ack", 32'(src_ack), 32'h0);
      check("er1_busy", 32'(busy), 32'h1);
      check_out("er1", 1'b1, 8'h22, 2'd1, 1'b0);
      tick();
      #1;
      check("er2_ack", 32'(src_ack), 32'h8);
      check("er2_busy", 32'(busy), 32'h0);
      check("er2_rr", 32'(dbg.rr_ptr), 32'd3);
      check_out("er2", 1'b0, 8'h00, 2'd1, 1'b0);
      tick();
      set_src(3, 1'b0, 8'h33, 2'd0);
      #1;
      check("er3_busy", 32'(busy), 32'h1);
      check_out("er3", 1'b1, 8'h33, 2'd0, 1'b0);
      tick();
      #1;
      check("er4_busy", 32'(busy), 32'h0);
      tick();

      // ---- disabled destination port ----
      port_en = 4'b1011;
      set_src(1, 1'b1, 8'hA5, 2'd2);
      #1;
      check("dis0_ack", 32'(src_ack), 32'h2);
      tick();
      set_src(1, 1'b1, 8'h5A, 2'd3);
      #1;
      check("dis1_ack", 32'(src_ack), 32'h2);
      check_out("dis1", 1'b0, 8'h00, 2'd0, 1'b1);
      tick();
      set_src(1, 1'b0, 8'h5A, 2'd3);
      #1;
      check("dis2_ack", 32'(src_ack), 32'h0);
      check_out("dis2", 1'b1, 8'h5A, 2'd3, 1'b0);
      tick();
      port_en = 4'hF;

      // ---- wrap-around: pointer at 3, src3 idle, src0 beats src1 ----
      set_src(2, 1'b1, 8'h44, 2'd2);
      #1;
      check("wr0_ack", 32'(src_ack), 32'h4);
      tick();
      set_src(2, 1'b0, 8'h44, 2'd2);
      tick();
      set_src(0, 1'b1, 8'h60, 2'd0);
      set_src(1, 1'b1, 8'h61, 2'd1);
      #1;
      check("wr_rr", 32'(dbg.rr_ptr), 32'd3);
      check("wr_ack", 32'(src_ack), 32'h1);
      tick();
      set_src(0, 1'b0, 8'h60, 2'd0);
      set_src(1, 1'b0, 8'h61, 2'd1);
      tick();
      tick();

      // ---- reset in the middle of a burst ----
      set_src(0, 1'b1, 8'h71, 2'd1);
      #1;
      check("rb0_ack", 32'(src_ack), 32'h1);
      tick();
      set_src(0, 1'b1, 8'h72, 2'd1);
      reset = 1'b1;
      #1;
      check("rb1_ack", 32'(src_ack), 32'h0);
      check_out("rb1", 1'b1, 8'h71, 2'd1, 1'b0);
      tick();
      reset = 1'b0;
      set_src(1, 1'b1, 8'h81, 2'd3);
      #1;
      check_out("rb2", 1'b0, 8'h00, 2'd0, 1'b0);
      check("rb2_busy", 32'(busy), 32'h0);
      check("rb2_rr", 32'(dbg.rr_ptr), 32'd0);
      check("rb2_ack", 32'(src_ack), 32'h1);
      tick();
      set_src(0, 1'b0, 8'h72, 2'd1);
      set_src(1, 1'b0, 8'h81, 2'd3);
      #1;
      check("rb3_ack", 32'(src_ack), 32'h0);
      check_out("rb3", 1'b1, 8'h72, 2'd1, 1'b0);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
